vend_ctrl: RTL and testbench

Vending-machine sequencer that sits between the coin inputs and the two-digit money display decoder.
- Accumulates coin credit in half-unit steps against a fixed price and decides vend, change and refund.
- Drives the decoder's money_flag code (0..6 means 0.0..3.0 in 0.5 steps).
- Generates the time-multiplexed active-low digit select sel that scans the two display digits.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_if.sv | 24 ++
 rtl/vend_scan_div.sv | 30 +++
 rtl/vend_ctrl.sv | 111 +++++++++++
 tb/tb_vend_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared encodings and constants for the vending-machine sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] ONE  = 2'd2;

    localparam logic [5:0] SEL_D0 = 6'b111110;
    localparam logic [5:0] SEL_D1 = 6'b111101;

    localparam int FLAG_W = 4;

    // Credit in half-units maps directly onto the decoder code.
    function automatic logic [FLAG_W-1:0] to_flag(input logic [2:0] halves);
        return {{(FLAG_W-3){1'b0}}, halves};
    endfunction

endpackage

// File: rtl/vend_if.sv
// Coin inputs and display/vend outputs of the sequencer, bundled.
interface vend_if;
    import vend_pkg::*;

    logic              coin_half;
    logic              coin_one;
    logic              cancel;
    logic [FLAG_W-1:0] money_flag;
    logic [5:0]        sel;
    logic              dispense;
    logic              change_valid;
    logic [2:0]        change_halves;

    modport master (
        output coin_half, coin_one, cancel,
        input  money_flag, sel, dispense, change_valid, change_halves
    );

    modport slave (
        input  coin_half, coin_one, cancel,
        output money_flag, sel, dispense, change_valid, change_halves
    );

endinterface

// File: rtl/vend_scan_div.sv
// Free-running dwell counter that alternates the active-low digit select.
module vend_scan_div
    import vend_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [5:0] sel
);

    localparam int            CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel <= SEL_D0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            // Only the two legal digit codes are ever produced.
            sel <= (sel == SEL_D0) ? SEL_D1 : SEL_D0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: credit accumulation, vend/refund decisions and
// the money_flag code for the two-digit display decoder.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_HALVES = 5,
    parameter int SCAN_DIV     = 50000,
    parameter int SHOW_CYC     = 25000000
) (
    input  logic   clk,
    input  logic   rst_n,
    vend_if.slave  bus
);

    localparam int                SHOW_W    = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
    localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
    localparam logic [2:0]        PRICE     = 3'(PRICE_HALVES);

    state_t            state, state_nxt;
    logic [2:0]        balance, balance_nxt;
    logic [FLAG_W-1:0] flag, flag_nxt;
    logic              dispense, dispense_nxt;
    logic              change_valid, change_valid_nxt;
    logic [2:0]        change, change_nxt;
    logic [SHOW_W-1:0] show_cnt, show_cnt_nxt;
    logic [1:0]        inc;
    logic [2:0]        sum;
    logic [5:0]        sel;

    // Max balance is PRICE-1 and max inc is 3, so 3 bits never overflow.
    assign inc = (bus.coin_half ? HALF : 2'd0) + (bus.coin_one ? ONE : 2'd0);
    assign sum = balance + {1'b0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            balance      <= '0;
            flag         <= '0;
            dispense     <= 1'b0;
            change_valid <= 1'b0;
            change       <= '0;
            show_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            balance      <= balance_nxt;
            flag         <= flag_nxt;
            dispense     <= dispense_nxt;
            change_valid <= change_valid_nxt;
            change       <= change_nxt;
            show_cnt     <= show_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        balance_nxt      = balance;
        flag_nxt         = flag;
        dispense_nxt     = 1'b0;
        change_valid_nxt = 1'b0;
        change_nxt       = change;
        show_cnt_nxt     = show_cnt;
        case (state)
            IDLE, ACCUM: begin
                // A completing purchase takes priority over a same-cycle cancel.
                if (sum >= PRICE) begin
                    dispense_nxt     = 1'b1;
                    change_valid_nxt = 1'b1;
                    change_nxt       = sum - PRICE;
                    flag_nxt         = to_flag(sum - PRICE);
                    balance_nxt      = '0;
                    show_cnt_nxt     = '0;
                    state_nxt        = SHOW;
                end else if (bus.cancel && (state == ACCUM || inc != 2'd0)) begin
                    change_valid_nxt = 1'b1;
                    change_nxt       = sum;
                    flag_nxt         = to_flag(sum);
                    balance_nxt      = '0;
                    show_cnt_nxt     = '0;
                    state_nxt        = SHOW;
                end else if (inc != 2'd0) begin
                    balance_nxt = sum;
                    flag_nxt    = to_flag(sum);
                    state_nxt   = ACCUM;
                end
            end
            SHOW: begin
                if (show_cnt == SHOW_LAST) begin
                    show_cnt_nxt = '0;
                    flag_nxt     = '0;
                    state_nxt    = IDLE;
                end else begin
                    show_cnt_nxt = show_cnt + SHOW_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    vend_scan_div #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel)
    );

    assign bus.money_flag    = flag;
    assign bus.sel           = sel;
    assign bus.dispense      = dispense;
    assign bus.change_valid  = change_valid;
    assign bus.change_halves = change;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl with SCAN_DIV=4, SHOW_CYC=8, PRICE_HALVES=5.
module tb_vend_ctrl;

    typedef struct {
        logic       disp;
        logic [2:0] chg;
        logic [3:0] flag;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ev_t  ev_q[$];
    int   flag_q[$];
    ev_t  ev_cur;
    int   flag_exp;
    logic [3:0] last_flag = 4'd0;

    vend_if bus ();

    vend_ctrl #(
        .PRICE_HALVES (5),
        .SCAN_DIV     (4),
        .SHOW_CYC     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin(input logic h, input logic o, input logic c);
        bus.coin_half = h;
        bus.coin_one  = o;
        bus.cancel    = c;
        @(negedge clk);
        bus.coin_half = 1'b0;
        bus.coin_one  = 1'b0;
        bus.cancel    = 1'b0;
    endtask

    task automatic exp_ev(input logic d, input logic [2:0] c, input logic [3:0] f);
        ev_t e;
        e.disp = d;
        e.chg  = c;
        e.flag = f;
        ev_q.push_back(e);
    endtask

    task automatic exp_flags(input int a, input int b, input int c, input int d);
        flag_q.push_back(a);
        flag_q.push_back(b);
        flag_q.push_back(c);
        flag_q.push_back(d);
    endtask

    // Event monitor: every dispense/change_valid cycle must match a queued event.
    always @(negedge clk) begin
        if (rst_n && (bus.dispense || bus.change_valid)) begin
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: dispense=%0b change_valid=%0b change=%0d",
                         bus.dispense, bus.change_valid, bus.change_halves);
            end else begin
                ev_cur = ev_q.pop_front();
                chk("ev_change_valid", int'(bus.change_valid), 1);
                chk("ev_dispense", int'(bus.dispense), int'(ev_cur.disp));
                chk("ev_change_halves", int'(bus.change_halves), int'(ev_cur.chg));
                chk("ev_money_flag", int'(bus.money_flag), int'(ev_cur.flag));
            end
        end
    end

    // Display monitor: every change of money_flag must match the next queued code.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_flag <= bus.money_flag;
        end else if (bus.money_flag != last_flag) begin
            if (flag_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flag: got %0d previous %0d", bus.money_flag, last_flag);
            end else begin
                flag_exp = flag_q.pop_front();
                chk("money_flag_step", int'(bus.money_flag), flag_exp);
            end
            last_flag <= bus.money_flag;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.coin_half = 1'b0;
        bus.coin_one  = 1'b0;
        bus.cancel    = 1'b0;

        // 1: reset values and scan timing
        tick(3);
        chk("rst_money_flag", int'(bus.money_flag), 0);
        chk("rst_sel", int'(bus.sel), int'(6'b111110));
        chk("rst_dispense", int'(bus.dispense), 0);
        chk("rst_change_valid", int'(bus.change_valid), 0);
        chk("rst_change_halves", int'(bus.change_halves), 0);
        rst_n = 1'b1;
        tick(3);
        chk("sel_hold_3", int'(bus.sel), int'(6'b111110));
        tick(1);
        chk("sel_after_4", int'(bus.sel), int'(6'b111101));
        tick(4);
        chk("sel_after_8", int'(bus.sel), int'(6'b111110));

        // 2: five half coins, exact price
        exp_flags(1, 2, 3, 4);
        flag_q.push_back(0);
        exp_ev(1'b1, 3'd0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            coin(1'b1, 1'b0, 1'b0);
            if (i < 4) tick(2);
        end
        tick(9);

        // 3: three one coins, change 1 shown for 8 cycles
        exp_flags(2, 4, 1, 0);
        exp_ev(1'b1, 3'd1, 4'd1);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b0, 1'b1, 1'b0);
        tick(7);
        chk("show_hold_7", int'(bus.money_flag), 1);
        tick(1);
        chk("show_end_8", int'(bus.money_flag), 0);
        tick(2);

        // 4: balance 4 then both coins at once
        exp_flags(2, 4, 2, 0);
        exp_ev(1'b1, 3'd2, 4'd2);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b1, 1'b1, 1'b0);
        tick(9);

        // 5: balance 3, cancel with a half coin, coin ignored during SHOW
        exp_flags(2, 3, 4, 0);
        exp_ev(1'b0, 3'd4, 4'd4);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b1, 1'b0, 1'b0);
        tick(2);
        coin(1'b1, 1'b0, 1'b1);
        tick(2);
        coin(1'b0, 1'b1, 1'b0);
        chk("show_ignore_coin_flag", int'(bus.money_flag), 4);
        chk("show_change_held", int'(bus.change_halves), 4);
        tick(6);
        chk("refund_show_end", int'(bus.money_flag), 0);

        // cancel alone in IDLE is ignored; cancel with a completing purchase loses
        coin(1'b0, 1'b0, 1'b1);
        tick(2);
        chk("idle_cancel_flag", int'(bus.money_flag), 0);
        chk("idle_cancel_change_held", int'(bus.change_halves), 4);
        exp_flags(2, 4, 1, 0);
        exp_ev(1'b1, 3'd1, 4'd1);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b0, 1'b1, 1'b0);
        tick(2);
        coin(1'b0, 1'b1, 1'b1);
        tick(10);

        // 6: asynchronous reset mid-ACCUM discards credit
        flag_q.push_back(2);
        coin(1'b0, 1'b1, 1'b0);
        tick(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flag", int'(bus.money_flag), 0);
        chk("async_rst_sel", int'(bus.sel), int'(6'b111110));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        flag_q.push_back(1);
        coin(1'b1, 1'b0, 1'b0);
        tick(2);
        chk("post_rst_credit", int'(bus.money_flag), 1);

        tick(2);
        chk("ev_queue_drained", ev_q.size(), 0);
        chk("flag_queue_drained", flag_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
